// File: rtl/md_unit_pkg.sv
// Shared multiply/divide opcodes used by the MD unit, the decoder and the hazard controller.
package md_unit_pkg;
   localparam int MD_OP_W = 4;

   localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
   localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
   localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
   localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
   localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
   localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd5;
   localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd6;
   localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd7;
   localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd8;

   function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction
endpackage

// File: rtl/md_unit_if.sv
// EX-stage request / status bundle between the pipeline and the MD unit.
interface md_unit_if;
   logic        E_start;
   logic [3:0]  E_md_op;
   logic [31:0] E_rs_data;
   logic [31:0] E_rt_data;
   logic        D_is_md;
   logic        busy;
   logic        md_stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output E_start, E_md_op, E_rs_data, E_rt_data, D_is_md,
                   input  busy, md_stall, hi, lo);
   modport slave  (input  E_start, E_md_op, E_rs_data, E_rt_data, D_is_md,
                   output busy, md_stall, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO; result computed at start, committed after latency.
// Optional MD_DIV0_HOLD_EN: divide by zero leaves HI/LO untouched instead of {dividend, all-ones}.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   md_unit_if.slave    md
);

`ifdef MD_DIV0_HOLD_EN
   localparam logic HOLD_DIV0 = 1'b1;
`else
   localparam logic HOLD_DIV0 = 1'b0;
`endif

   logic [31:0]      r_hi, r_lo, r_pend_hi, r_pend_lo;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy, r_hold;

   logic [63:0] w_prod_s, w_prod_u, w_res;
   logic [31:0] w_a, w_b, w_dvd, w_dvs, w_uq, w_ur, w_q, w_r;
   logic        w_sgn, w_div0;

   assign w_a    = md.E_rs_data;
   assign w_b    = md.E_rt_data;
   assign w_div0 = (w_b == 32'd0);
   assign w_sgn  = (md.E_md_op == MD_DIV);

   assign w_prod_s = 64'($signed(w_a) * $signed(w_b));
   assign w_prod_u = 64'(w_a) * 64'(w_b);

   // One unsigned divider on magnitudes; signs restored after, which also makes
   // 0x80000000 / -1 wrap to 0x80000000 rem 0 without special casing.
   assign w_dvd = (w_sgn && w_a[31]) ? -w_a : w_a;
   assign w_dvs = (w_sgn && w_b[31]) ? -w_b : w_b;
   assign w_uq  = w_div0 ? 32'd0 : w_dvd / w_dvs;
   assign w_ur  = w_div0 ? 32'd0 : w_dvd % w_dvs;
   assign w_q   = (w_sgn && (w_a[31] ^ w_b[31])) ? -w_uq : w_uq;
   assign w_r   = (w_sgn && w_a[31]) ? -w_ur : w_ur;

   always_comb begin
      w_res = 64'd0;
      case (md.E_md_op)
         MD_MULT:          w_res = w_prod_s;
         MD_MULTU:         w_res = w_prod_u;
         MD_DIV, MD_DIVU:  w_res = w_div0 ? {w_a, 32'hFFFF_FFFF} : {w_r, w_q};
         default:          w_res = 64'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_hold    <= 1'b0;
      end else if (r_busy) begin
         // Requests arriving while busy are dropped; the hazard controller keeps them in D.
         if (r_cnt == CNT_W'(1)) begin
            if (!r_hold) begin
               r_hi <= r_pend_hi;
               r_lo <= r_pend_lo;
            end
            r_cnt  <= '0;
            r_busy <= 1'b0;
         end else begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end else if (md.E_start) begin
         case (md.E_md_op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
               {r_pend_hi, r_pend_lo} <= w_res;
               r_cnt  <= md_is_div(md.E_md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
               r_busy <= 1'b1;
               r_hold <= HOLD_DIV0 & md_is_div(md.E_md_op) & w_div0;
            end
            MD_MTHI: r_hi <= w_a;
            MD_MTLO: r_lo <= w_a;
            default: ;
         endcase
      end
   end

   assign md.busy     = r_busy;
   assign md.md_stall = md.D_is_md & (r_busy | md.E_start);
   assign md.hi       = r_hi;
   assign md.lo       = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: scoreboarded MD results, stall timing, mt rules, div0 and reset.
module tb_md_unit;
   import md_unit_pkg::*;

   localparam int LAT_M = 5;
   localparam int LAT_D = 10;

   logic clk = 1'b0;
   logic rst_n;
   int   n_pass = 0;
   int   n_total = 0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
   logic [63:0] sb[$];

   md_unit_if mif ();

   md_unit #(.MULT_CYCLES(LAT_M), .DIV_CYCLES(LAT_D), .CNT_W(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .md   (mif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb_, q, r;
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      if ((op == MD_DIV || op == MD_DIVU) && b == 32'd0) begin
`ifdef MD_DIV0_HOLD_EN
         return {m_hi, m_lo};
`else
         return {a, 32'hFFFF_FFFF};
`endif
      end
      case (op)
         MD_MULT:  return 64'(sa * sb_);
         MD_MULTU: return 64'(a) * 64'(b);
         MD_DIV: begin
            q = sa / sb_;
            r = sa % sb_;
            return {r[31:0], q[31:0]};
         end
         MD_DIVU:  return {a % b, a / b};
         default:  return {m_hi, m_lo};
      endcase
   endfunction

   // Issues one mult/div, tracks the busy window and checks the committed result.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic dmd, input logic inj);
      int n, lat;
      logic [63:0] e;
      lat = (op == MD_DIV || op == MD_DIVU) ? LAT_D : LAT_M;
      @(negedge clk);
      mif.E_start = 1'b1; mif.E_md_op = op; mif.E_rs_data = a; mif.E_rt_data = b;
      mif.D_is_md = dmd;
      #1;
      chk("stall_start", 32'(mif.md_stall), 32'(dmd));
      sb.push_back(model(op, a, b));
      n = 0;
      @(negedge clk);
      mif.E_start = 1'b0;
      #1;
      while (mif.busy === 1'b1 && n < 40) begin
         chk("stall_busy", 32'(mif.md_stall), 32'(dmd));
         if (inj && n == 1) begin
            mif.E_start = 1'b1; mif.E_md_op = MD_MTLO; mif.E_rs_data = 32'h1234;
         end
         @(negedge clk);
         mif.E_start = 1'b0;
         #1;
         n++;
      end
      chk("busy_cycles", 32'(n), 32'(lat));
      chk("stall_fall", 32'(mif.md_stall), 32'd0);
      e = sb.pop_front();
      chk("hi", mif.hi, e[63:32]);
      chk("lo", mif.lo, e[31:0]);
      m_hi = e[63:32];
      m_lo = e[31:0];
      mif.D_is_md = 1'b0;
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] v);
      @(negedge clk);
      mif.E_start = 1'b1; mif.E_md_op = op; mif.E_rs_data = v;
      @(negedge clk);
      mif.E_start = 1'b0;
      #1;
      if (op == MD_MTHI) m_hi = v;
      if (op == MD_MTLO) m_lo = v;
      chk("mt_busy", 32'(mif.busy), 32'd0);
      chk("mt_hi", mif.hi, m_hi);
      chk("mt_lo", mif.lo, m_lo);
   endtask

   initial begin
      rst_n = 1'b0;
      mif.E_start = 1'b0; mif.E_md_op = MD_NONE; mif.E_rs_data = '0; mif.E_rt_data = '0;
      mif.D_is_md = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", 32'(mif.busy), 32'd0);
      chk("rst_hi", mif.hi, 32'd0);
      chk("rst_lo", mif.lo, 32'd0);
      chk("rst_stall", 32'(mif.md_stall), 32'd0);
      mif.D_is_md = 1'b1; mif.E_start = 1'b1;
      #1;
      chk("rst_stall_start", 32'(mif.md_stall), 32'd1);
      mif.D_is_md = 1'b0; mif.E_start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
      chk("mult_hi_const", mif.hi, 32'hFFFF_FFFF);
      chk("mult_lo_const", mif.lo, 32'hFFFF_FFF1);
      run_op(MD_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
      chk("divu_lo_const", mif.lo, 32'd3);
      chk("divu_hi_const", mif.hi, 32'd1);
      run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      chk("div_lo_const", mif.lo, 32'hFFFF_FFFD);
      chk("div_hi_const", mif.hi, 32'hFFFF_FFFF);
      run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      chk("ovf_lo_const", mif.lo, 32'h8000_0000);
      chk("ovf_hi_const", mif.hi, 32'd0);
      run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);

      // mtlo injected while busy must be dropped
      run_op(MD_MULT, 32'd6, 32'd7, 1'b0, 1'b1);
      chk("mt_ignored_lo", mif.lo, 32'd42);
      mt(MD_MTLO, 32'h1234);
      mt(MD_MFHI, 32'h0);

      for (int i = 0; i < 4; i++)
         run_op(4'(1 + (i % 4)), $urandom, $urandom_range(1, 32'h7FFF_FFFF), 1'b0, 1'b0);

      mt(MD_MTHI, 32'hAA);
      mt(MD_MTLO, 32'hBB);
      run_op(MD_DIV, 32'h55, 32'd0, 1'b0, 1'b0);
`ifdef MD_DIV0_HOLD_EN
      chk("div0_hi_const", mif.hi, 32'hAA);
      chk("div0_lo_const", mif.lo, 32'hBB);
`else
      chk("div0_hi_const", mif.hi, 32'h55);
      chk("div0_lo_const", mif.lo, 32'hFFFF_FFFF);
`endif
      run_op(MD_DIVU, 32'h1234_5678, 32'd0, 1'b0, 1'b0);

      // reset two cycles into a div discards the pending result
      mt(MD_MTHI, 32'hCAFE);
      @(negedge clk);
      mif.E_start = 1'b1; mif.E_md_op = MD_DIV; mif.E_rs_data = 32'd100; mif.E_rt_data = 32'd7;
      @(negedge clk);
      mif.E_start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(mif.busy), 32'd0);
      chk("arst_hi", mif.hi, 32'd0);
      chk("arst_lo", mif.lo, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      #1;
      chk("post_rst_busy", 32'(mif.busy), 32'd0);
      chk("post_rst_hi", mif.hi, 32'd0);
      chk("post_rst_lo", mif.lo, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
